// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: takes one PC, issues a single imem read, and holds
// {pc, instr, fault} for decode. Misaligned PCs bypass memory and present a NOP.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | ready for a new PC from the next-PC generator
// S_REQ   | read request presented to imem, waiting for acceptance
// S_WAIT  | request accepted, waiting for the response
// S_DRAIN | flushed with a request in flight; swallow its response
// S_HOLD  | result presented to decode until consumed
module if_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic            pc_valid,
  output logic            pc_ready,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic            id_fault
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [2:0]      state;
  logic [XLEN-1:0] pc_lat;

  assign pc_ready       = (state == S_IDLE);
  assign imem_req_valid = (state == S_REQ);
  assign id_valid       = (state == S_HOLD);
  assign imem_req_addr  = pc_lat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      pc_lat   <= '0;
      id_pc    <= RESET_PC;
      id_instr <= NOP;
      id_fault <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!flush && pc_valid) begin
            pc_lat <= pc_in;
            if (pc_in[1:0] == 2'b00) begin
              state <= S_REQ;
            end else begin
              state    <= S_HOLD;
              id_pc    <= pc_in;
              id_instr <= NOP;
              id_fault <= 1'b1;
            end
          end
        end
        S_REQ: begin
          // An accepted-then-flushed request still owes us one response.
          if (flush) state <= imem_req_ready ? S_DRAIN : S_IDLE;
          else if (imem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (flush) begin
            state <= imem_resp_valid ? S_IDLE : S_DRAIN;
          end else if (imem_resp_valid) begin
            state    <= S_HOLD;
            id_pc    <= pc_lat;
            id_instr <= imem_resp_data;
            id_fault <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (imem_resp_valid) state <= S_IDLE;
        end
        S_HOLD: begin
          if (flush || id_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: stimulus pushes expected decode results into
// a queue, a monitor pops and compares on each id_valid/id_ready handshake.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_fault;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  if_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_instr(id_instr), .id_fault(id_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every result decode actually consumes.
  always @(negedge clk) begin
    if (rst && !flush && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output_pc", {32'h0, id_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_pc",    {32'h0, id_pc},    {32'h0, e.pc});
        chk("out_instr", {32'h0, id_instr}, {32'h0, e.instr});
        chk("out_fault", {63'h0, id_fault}, {63'h0, e.fault});
      end
    end
  end

  // Aligned fetch with optional request and decode backpressure.
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data,
                          input int req_stall, input int id_stall);
    pc_in = pc; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    for (int i = 0; i < req_stall; i++) begin
      chk("req_valid_held", {63'h0, imem_req_valid}, 64'h1);
      chk("req_addr_held",  {32'h0, imem_req_addr},  {32'h0, pc});
      tick();
    end
    chk("req_valid", {63'h0, imem_req_valid}, 64'h1);
    chk("req_addr",  {32'h0, imem_req_addr},  {32'h0, pc});
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = data;
    tick();
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    chk("id_valid_up", {63'h0, id_valid}, 64'h1);
    // Offer a competing PC during the hold; it must not be taken.
    pc_in = pc + 32'h100; pc_valid = (id_stall > 0);
    for (int i = 0; i < id_stall; i++) begin
      chk("hold_pc",       {32'h0, id_pc},    {32'h0, pc});
      chk("hold_instr",    {32'h0, id_instr}, {32'h0, data});
      chk("hold_pc_ready", {63'h0, pc_ready}, 64'h0);
      tick();
    end
    pc_valid = 1'b0;
    chk("pc_ready_in_hold", {63'h0, pc_ready}, 64'h0);
    exp_q.push_back('{pc: pc, instr: data, fault: 1'b0});
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    chk("pc_ready_after", {63'h0, pc_ready}, 64'h1);
  endtask

  initial begin
    rst = 1'b0; pc_in = '0; pc_valid = 1'b0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; flush = 1'b0; id_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    chk("rst_pc_ready", {63'h0, pc_ready},       64'h1);
    chk("rst_req_valid",{63'h0, imem_req_valid}, 64'h0);
    chk("rst_req_addr", {32'h0, imem_req_addr},  64'h0);
    chk("rst_id_valid", {63'h0, id_valid},       64'h0);
    chk("rst_id_pc",    {32'h0, id_pc},          64'h0);
    chk("rst_id_instr", {32'h0, id_instr},       {32'h0, NOP});
    chk("rst_id_fault", {63'h0, id_fault},       64'h0);

    // Basic fetch, then request + decode backpressure.
    do_fetch(32'h0000_0004, 32'h0050_0093, 0, 0);
    do_fetch(32'h0000_0008, 32'h0010_8113, 3, 4);

    // Misaligned PC: straight to HOLD, no memory request.
    pc_in = 32'h0000_0006; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    chk("mis_no_req",   {63'h0, imem_req_valid}, 64'h0);
    chk("mis_id_valid", {63'h0, id_valid},       64'h1);
    chk("mis_fault",    {63'h0, id_fault},       64'h1);
    exp_q.push_back('{pc: 32'h6, instr: NOP, fault: 1'b1});
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;

    // Flush in WAIT; late response must be swallowed.
    pc_in = 32'h0000_0010; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("drain_pc_ready", {63'h0, pc_ready}, 64'h0);
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0;
    chk("wflush_id_valid", {63'h0, id_valid}, 64'h0);
    chk("wflush_pc_ready", {63'h0, pc_ready}, 64'h1);
    do_fetch(32'h0000_0020, 32'h0020_0113, 0, 0);

    // Flush coincident with request acceptance.
    pc_in = 32'h0000_0030; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_req_ready = 1'b1; flush = 1'b1;
    tick();
    imem_req_ready = 1'b0; flush = 1'b0;
    chk("rflush_req_drop", {63'h0, imem_req_valid}, 64'h0);
    chk("rflush_drain",    {63'h0, pc_ready},       64'h0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_BAD0;
    tick();
    imem_resp_valid = 1'b0;
    chk("rflush_idle", {63'h0, pc_ready}, 64'h1);
    do_fetch(32'h0000_0034, 32'h0030_0193, 0, 0);

    // Flush in HOLD drops the result.
    pc_in = 32'h0000_0040; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h1234_5678;
    tick();
    imem_resp_valid = 1'b0;
    chk("hflush_pre", {63'h0, id_valid}, 64'h1);
    flush = 1'b1; id_ready = 1'b1;
    tick();
    flush = 1'b0; id_ready = 1'b0;
    chk("hflush_id_valid", {63'h0, id_valid}, 64'h0);
    chk("hflush_pc_ready", {63'h0, pc_ready}, 64'h1);

    // Reset mid-WAIT, then a stale response.
    pc_in = 32'h0000_0050; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; rst = 1'b0;
    tick();
    rst = 1'b1; imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_1111;
    tick();
    imem_resp_valid = 1'b0;
    tick();
    chk("mrst_id_valid",  {63'h0, id_valid},       64'h0);
    chk("mrst_pc_ready",  {63'h0, pc_ready},       64'h1);
    chk("mrst_id_pc",     {32'h0, id_pc},          64'h0);
    chk("mrst_id_instr",  {32'h0, id_instr},       {32'h0, NOP});
    chk("mrst_id_fault",  {63'h0, id_fault},       64'h0);
    chk("mrst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("mrst_req_addr",  {32'h0, imem_req_addr},  64'h0);

    tick();
    chk("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage directly downstream of the next-PC generator. Accepts one PC per handshake and issues a single read to instruction memory over a valid/ready request channel. Captures the returned instruction word and presents {pc, instr} to the decode stage through a valid/ready output register. Supports flush on redirect and flags misaligned PCs without accessing memory.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, value of id_pc after reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-low reset; rst==0 at a rising edge resets the block
pc_in  in  XLEN  PC from next-PC generator
pc_valid  in  1  pc_in is valid
pc_ready  out  1  fetch accepts pc_in this cycle
imem_req_valid  out  1  read request to instruction memory
imem_req_addr  out  XLEN  request address; word-aligned
imem_req_ready  in  1  memory accepts request
imem_resp_valid  in  1  read data valid; one response per accepted request, at least 1 cycle after acceptance
imem_resp_data  in  XLEN  instruction word
flush  in  1  redirect: discard the current fetch
id_valid  out  1  {id_pc, id_instr, id_fault} valid toward decode
id_ready  in  1  decode consumes the output
id_pc  out  XLEN  PC of the presented instruction
id_instr  out  XLEN  instruction word; 32'h0000_0013 (NOP) when id_fault=1
id_fault  out  1  pc was misaligned (pc[1:0]!=0)

Behaviour:
- Reset (rst==0 at a rising edge): state=IDLE; pc_ready=1; imem_req_valid=0; imem_req_addr=0; id_valid=0; id_pc=RESET_PC; id_instr=32'h0000_0013; id_fault=0. Reset overrides flush and all handshakes, including mid-request; a response arriving after reset is ignored.
- States: IDLE, REQ, WAIT, DRAIN, HOLD. Only one memory request is outstanding at a time.
- IDLE: pc_ready=1. On pc_valid: latch pc_in. If pc_in[1:0]==0, go to REQ. Otherwise go to HOLD with id_fault=1, id_instr=NOP, id_pc=pc_in, and issue no memory request.
- REQ: imem_req_valid=1 with imem_req_addr=latched PC, held stable until imem_req_ready. On acceptance go to WAIT.
- WAIT: on imem_resp_valid, register id_instr=imem_resp_data, id_pc=latched PC, id_fault=0, id_valid=1, and go to HOLD.
- HOLD: id_valid=1 and the outputs stay stable until id_ready. On id_ready go to IDLE; pc_ready rises in the following cycle (no same-cycle accept).
- pc_ready=1 only in IDLE. imem_req_valid=1 only in REQ. id_valid=1 only in HOLD.
- Fetch latency: PC accept to id_valid is at least 3 cycles with immediate req_ready and 1-cycle memory response.
- flush (lower priority than reset, higher than every handshake):
  - IDLE: the pc_valid in the same cycle is ignored; stay in IDLE.
  - REQ: drop the request (imem_req_valid=0 next cycle), even if imem_req_ready is high that cycle. If it was accepted that cycle, go to DRAIN; otherwise go to IDLE.
  - WAIT: go to DRAIN. If imem_resp_valid arrives in the same cycle, discard it and go to IDLE.
  - DRAIN: discard the next imem_resp_valid, then go to IDLE. Further flushes keep the block in DRAIN.
  - HOLD: id_valid=0 next cycle; go to IDLE even if id_ready was high.
- A response arriving outside WAIT/DRAIN is ignored.
- No arithmetic; addresses pass through unmodified.

Test Plan:
- Basic fetch: reset, then pc_in=0x0000_0004 with pc_valid=1, memory always ready, response 1 cycle later with 0x00500093 -> id_valid=1 with id_pc=0x4, id_instr=0x00500093, id_fault=0; pc_ready=0 until id_ready is seen.
- Backpressure: imem_req_ready low for 3 cycles -> imem_req_valid and imem_req_addr=0x8 held stable. Then id_ready low for 4 cycles -> id_pc and id_instr held unchanged, and no new PC accepted.
- Misaligned: pc_in=0x0000_0006 -> no imem_req_valid pulse; id_valid=1, id_fault=1, id_instr=0x00000013, id_pc=0x6.
- Flush in WAIT: accept PC 0x10, assert flush before the response, response 0xDEADBEEF arrives 2 cycles later -> 0xDEADBEEF never appears on id_instr. The next PC 0x20 fetches normally with its own data.
- Flush coincident with request acceptance in REQ -> DRAIN consumes exactly one response; the next fetch's id_instr matches its own response.
- Reset mid-WAIT: rst=0 for one cycle, then a late response arrives -> outputs hold reset values, id_valid stays 0, pc_ready=1.
